// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default bit period.
// Used by both the receiver and the transmitter so their frames agree.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

    localparam int CLKS_PER_BIT_DEFAULT = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus one history flop.
// Every flop resets to the idle-high level, so no falling edge is reported during reset.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_fall_edge
);

    logic r_meta;
    logic r_rx_s;
    logic r_rx_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta    <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_meta    <= i_rx;
            r_rx_s    <= r_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    assign o_rx_s      = r_rx_s;
    assign o_fall_edge = r_rx_prev & ~r_rx_s;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling.
// Received byte is held on a valid/ack register; framing and overrun errors pulse for one cycle.
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronised line
// START | counting to mid start bit; line must still be low
// DATA  | sampling 8 data bits, one per bit period
// STOP  | sampling the stop bit, then deliver or flag an error
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_in,
    output logic [7:0] o_data,
    output logic       o_data_valid,
    input  logic       i_data_ack,
    output logic       o_frame_err,
    output logic       o_overrun_err,
    output logic       o_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);

    logic        w_rx_s;
    logic        w_fall_edge;

    uart_state_t r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_frame_err;
    logic        r_overrun_err;

    uart_rx_sync u_sync (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rx        (i_rx_in),
        .o_rx_s      (w_rx_s),
        .o_fall_edge (w_fall_edge)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
            if (i_data_ack && r_valid)
                r_valid <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_fall_edge) begin
                        r_state <= START;
                        r_cnt   <= '0;
                    end
                end
                START: begin
                    if (r_cnt == HALF_TC) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == FULL_TC) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7)
                            r_state <= STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Leaving at mid stop bit leaves half a bit of margin to catch the next start.
                    if (r_cnt == FULL_TC) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        if (w_rx_s) begin
                            if (!r_valid || i_data_ack) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end else begin
                                r_overrun_err <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_data        = r_data;
    assign o_data_valid  = r_valid;
    assign o_frame_err   = r_frame_err;
    assign o_overrun_err = r_overrun_err;
    assign o_busy        = (r_state != IDLE);

endmodule
